// File: rtl/alut_apb_master.sv
// APB initiator for the ALUT register bank: queues read/write/poll requests
// in a small FIFO and replays them as APB setup/access transfers.
module alut_apb_master #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_MAX   = 255
) (
  input  logic              pclk,
  input  logic              p_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_poll,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_mask,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              write;
    logic              poll;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mask;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state, state_next;
  req_t              fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty, push, pop;
  req_t              head;
  logic              is_poll, match, last_try, done;
  logic [7:0]        poll_cnt;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign req_ready = ~full;
  assign push      = req_valid & req_ready;
  assign head      = fifo_q[rd_ptr];
  assign busy      = (state != IDLE) | ~empty;

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{write: req_write, poll: req_poll, addr: req_addr,
                            wdata: req_wdata, mask: req_mask};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign is_poll  = ~head.write & head.poll;
  assign match    = ((prdata ^ head.wdata) & head.mask) == '0;
  assign last_try = (poll_cnt == 8'(POLL_MAX - 1));
  assign done     = ~is_poll | match | last_try;

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) state <= IDLE;
    else         state <= state_next;
  end

  // A push landing on the same edge lets IDLE go straight to SETUP, and keeps
  // ACCESS chaining into SETUP when the pop would otherwise empty the FIFO.
  always_comb begin
    state_next = state;
    psel       = 1'b0;
    penable    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty || push) state_next = SETUP;
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (done) begin
          pop        = 1'b1;
          state_next = (count > CNT_W'(1) || push) ? SETUP : IDLE;
        end else begin
          state_next = SETUP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus fields follow the FIFO head during a transfer and hold their last
  // driven values while idle.
  assign pwrite = (state == IDLE) ? write_q : head.write;
  assign paddr  = (state == IDLE) ? addr_q  : head.addr;
  assign pwdata = (state == IDLE) ? wdata_q : (head.write ? head.wdata : '0);

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      poll_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      if (state == ACCESS) begin
        write_q <= pwrite;
        addr_q  <= paddr;
        wdata_q <= pwdata;
        if (done) begin
          poll_cnt    <= '0;
          rsp_valid   <= 1'b1;
          rsp_write   <= head.write;
          rsp_rdata   <= head.write ? '0 : prdata;
          rsp_timeout <= is_poll & ~match;
        end else begin
          poll_cnt <= poll_cnt + 8'd1;
        end
      end
    end
  end

endmodule
